ram_access_arbiter: RTL and testbench

Sequences the single-port SPI RAM command interface (10-bit `rx_data` with 2-bit control field plus `rx_valid`, returning `dout`/`tx_valid`) on behalf of two independent requesters. Each requester issues whole word transactions (write or read). The block arbitrates between them round-robin and expands each transaction into the RAM's two-phase command sequence: WR_ADDR→WR_DATA or RD_ADDR→RD_DATA. It sits between the system-side masters and the RAM in place of the SPI slave's direct RAM drive.

---
 rtl/ram_access_arbiter.sv | 150 +++++++++++++++
 tb/tb_ram_access_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_access_arbiter
// Purpose  : Round-robin arbiter for two requesters in front of a single-port
//            SPI RAM; expands each word transaction into the two-phase command.
// Revision : 1.0
// ============================================================================
module ram_access_arbiter #(
    parameter int MEM_WIDTH = 8,
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req,
    input  logic [1:0]             we,
    input  logic [2*ADDR_SIZE-1:0] addr,
    input  logic [2*MEM_WIDTH-1:0] wdata,
    output logic [1:0]             ack,
    output logic                   err,
    output logic [MEM_WIDTH-1:0]   rdata,
    output logic                   busy,
    output logic [MEM_WIDTH+1:0]   rx_data,
    output logic                   rx_valid,
    input  logic [MEM_WIDTH-1:0]   dout,
    input  logic                   tx_valid
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] C_IDLE    = 3'd0;
    localparam logic [2:0] C_ADDR    = 3'd1;
    localparam logic [2:0] C_DATA    = 3'd2;
    localparam logic [2:0] C_WAIT_RD = 3'd3;
    localparam logic [2:0] C_DONE    = 3'd4;

    localparam logic [1:0] C_WR_ADDR = 2'b00;
    localparam logic [1:0] C_WR_DATA = 2'b01;
    localparam logic [1:0] C_RD_ADDR = 2'b10;
    localparam logic [1:0] C_RD_DATA = 2'b11;

    localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

    logic [2:0]           r_state;
    logic                 r_ptr;
    logic                 r_gnt;
    logic                 r_we;
    logic [MEM_WIDTH-1:0] r_wdata;
    logic [CW-1:0]        r_cnt;

    logic                 w_gnt;
    logic                 w_we;
    logic [ADDR_SIZE-1:0] w_addr;
    logic [MEM_WIDTH-1:0] w_wdata;
    logic [MEM_WIDTH-1:0] w_addr_ext;

    // Contention goes to r_ptr, which always names the requester not served last.
    always_comb begin
        if (req == 2'b11) begin
            w_gnt = r_ptr;
        end else begin
            w_gnt = req[1];
        end
        w_we    = w_gnt ? we[1] : we[0];
        w_addr  = w_gnt ? addr[2*ADDR_SIZE-1:ADDR_SIZE] : addr[ADDR_SIZE-1:0];
        w_wdata = w_gnt ? wdata[2*MEM_WIDTH-1:MEM_WIDTH] : wdata[MEM_WIDTH-1:0];
        w_addr_ext = '0;
        w_addr_ext[ADDR_SIZE-1:0] = w_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= C_IDLE;
            r_ptr    <= 1'b0;
            r_gnt    <= 1'b0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            ack      <= 2'b00;
            err      <= 1'b0;
            rdata    <= '0;
            busy     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (|req) begin
                        r_gnt    <= w_gnt;
                        r_ptr    <= ~w_gnt;
                        r_we     <= w_we;
                        r_wdata  <= w_wdata;
                        rx_data  <= {(w_we ? C_WR_ADDR : C_RD_ADDR), w_addr_ext};
                        rx_valid <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= C_ADDR;
                    end
                end
                C_ADDR: begin
                    rx_data <= {(r_we ? C_WR_DATA : C_RD_DATA),
                                (r_we ? r_wdata : {MEM_WIDTH{1'b0}})};
                    r_state <= C_DATA;
                end
                C_DATA: begin
                    rx_valid <= 1'b0;
                    rx_data  <= '0;
                    if (r_we) begin
                        ack     <= r_gnt ? 2'b10 : 2'b01;
                        err     <= 1'b0;
                        r_state <= C_DONE;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= C_WAIT_RD;
                    end
                end
                C_WAIT_RD: begin
                    if (tx_valid) begin
                        rdata   <= dout;
                        ack     <= r_gnt ? 2'b10 : 2'b01;
                        err     <= 1'b0;
                        r_state <= C_DONE;
                    end else if (r_cnt == C_CNT_LAST) begin
                        rdata   <= '0;
                        ack     <= r_gnt ? 2'b10 : 2'b01;
                        err     <= 1'b1;
                        r_state <= C_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                C_DONE: begin
                    ack     <= 2'b00;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= C_IDLE;
                end
                default: begin
                    ack      <= 2'b00;
                    err      <= 1'b0;
                    busy     <= 1'b0;
                    rx_valid <= 1'b0;
                    rx_data  <= '0;
                    r_state  <= C_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_access_arbiter
// Purpose  : Directed vector bench for ram_access_arbiter with a small RAM model.
// Revision : 1.0
// ============================================================================
module tb_ram_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  ack;
    logic        err;
    logic [7:0]  rdata;
    logic        busy;
    logic [9:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  dout;
    logic        tx_valid;

    logic        ram_on;
    logic [7:0]  ram_addr;
    logic [7:0]  mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    ram_access_arbiter #(.MEM_WIDTH(8), .ADDR_SIZE(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .err(err), .rdata(rdata), .busy(busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .dout(dout), .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;

    // Compliant RAM: read data strobed one cycle after the RD_DATA command.
    always @(posedge clk) begin
        tx_valid <= 1'b0;
        if (rx_valid) begin
            case (rx_data[9:8])
                2'b00, 2'b10: ram_addr <= rx_data[7:0];
                2'b01:        mem[ram_addr] <= rx_data[7:0];
                default: begin
                    if (ram_on) begin
                        tx_valid <= 1'b1;
                        dout     <= mem[ram_addr];
                    end
                end
            endcase
        end
    end

    typedef struct {
        logic       idx;
        logic       wr;
        logic [7:0] a;
        logic [7:0] d;
        logic       ram_en;
        logic       scramble;
        logic [9:0] rx0;
        logic [9:0] rx1;
        logic       exp_err;
        logic [7:0] exp_rdata;
        int         lat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts and ends one step after a rising edge with the DUT in IDLE.
    task automatic run_vec(input vec_t v);
        logic [1:0] exp_ack;
        int         lat;
        exp_ack = v.idx ? 2'b10 : 2'b01;
        ram_on  = v.ram_en;
        req     = 2'b00;
        req[v.idx] = 1'b1;
        we[v.idx]  = v.wr;
        addr[v.idx*8 +: 8]  = v.a;
        wdata[v.idx*8 +: 8] = v.d;
        @(posedge clk); #1;
        check("addr_cmd", {22'd0, rx_data}, {22'd0, v.rx0});
        check("addr_valid", {31'd0, rx_valid}, 32'd1);
        check("busy", {31'd0, busy}, 32'd1);
        if (v.scramble) begin
            addr[v.idx*8 +: 8]  = 8'h11;
            wdata[v.idx*8 +: 8] = 8'hFF;
        end
        @(posedge clk); #1;
        check("data_cmd", {22'd0, rx_data}, {22'd0, v.rx1});
        check("data_valid", {31'd0, rx_valid}, 32'd1);
        lat = 1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            lat++;
            check("idle_valid", {31'd0, rx_valid}, 32'd0);
            if (ack != 2'b00) break;
        end
        check("ack", {30'd0, ack}, {30'd0, exp_ack});
        check("latency", lat, v.lat);
        check("err", {31'd0, err}, {31'd0, v.exp_err});
        check("rdata", {24'd0, rdata}, {24'd0, v.exp_rdata});
        req = 2'b00;
        @(posedge clk); #1;
        check("ack_clear", {30'd0, ack}, 32'd0);
        check("busy_clear", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int d0;
        int d1;
        int run;
        logic exp_g;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        vecs[0] = '{1'b0, 1'b1, 8'h12, 8'hA5, 1'b1, 1'b0, 10'h012, 10'h1A5, 1'b0, 8'h00, 2};
        vecs[1] = '{1'b1, 1'b0, 8'h12, 8'h00, 1'b1, 1'b0, 10'h212, 10'h300, 1'b0, 8'hA5, 3};
        vecs[2] = '{1'b1, 1'b1, 8'h34, 8'h5A, 1'b1, 1'b0, 10'h034, 10'h15A, 1'b0, 8'hA5, 2};
        vecs[3] = '{1'b0, 1'b0, 8'h34, 8'h00, 1'b1, 1'b0, 10'h234, 10'h300, 1'b0, 8'h5A, 3};
        vecs[4] = '{1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 10'h212, 10'h300, 1'b1, 8'h00, 6};
        vecs[5] = '{1'b0, 1'b0, 8'h12, 8'h00, 1'b1, 1'b0, 10'h212, 10'h300, 1'b0, 8'hA5, 3};
        vecs[6] = '{1'b0, 1'b1, 8'h77, 8'h3C, 1'b1, 1'b1, 10'h077, 10'h13C, 1'b0, 8'hA5, 2};
        vecs[7] = '{1'b1, 1'b0, 8'h77, 8'h00, 1'b1, 1'b0, 10'h277, 10'h300, 1'b0, 8'h3C, 3};

        rst = 1'b1; req = 2'b00; we = 2'b00; addr = '0; wdata = '0; ram_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {18'd0, ack, err, rdata, busy, rx_valid},  32'd0);
        check("rst_rx_data", {22'd0, rx_data}, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        check("latched_write", {24'd0, mem[8'h77]}, 32'h3C);
        check("no_stray_write", {24'd0, mem[8'h11]}, 32'h00);

        // Async reset while the DATA command of a write is on the bus.
        req = 2'b01; we = 2'b01; addr[7:0] = 8'h20; wdata[7:0] = 8'h99;
        @(posedge clk);
        @(posedge clk); #2;
        check("pre_rst_valid", {31'd0, rx_valid}, 32'd1);
        rst = 1'b1; #1;
        check("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_ack", {30'd0, ack}, 32'd0);
        check("rst_mid_rx", {22'd0, rx_data}, 32'd0);
        req = 2'b00;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ack", {30'd0, ack}, 32'd0);

        // Both requesters contend continuously; grants must alternate from 0.
        we = 2'b11; addr = 16'h5040; wdata = 16'hBBAA;
        req = 2'b11; d0 = 0; d1 = 0; run = 0; exp_g = 1'b0;
        for (int c = 0; c < 80 && (d0 < 3 || d1 < 3); c++) begin
            @(posedge clk); #1;
            if (rx_valid) begin
                run++;
            end else if (run != 0) begin
                check("rv_run_len", run, 2);
                run = 0;
            end
            if (ack != 2'b00) begin
                check("rr_grant", {30'd0, ack}, exp_g ? 32'd2 : 32'd1);
                exp_g = ~exp_g;
                if (ack[0]) begin d0++; if (d0 == 3) req[0] = 1'b0; end
                if (ack[1]) begin d1++; if (d1 == 3) req[1] = 1'b0; end
            end
        end
        check("rr_total", d0 + d1, 6);
        @(posedge clk); #1;
        check("rr_idle", {31'd0, busy}, 32'd0);
        check("rr_mem0", {24'd0, mem[8'h40]}, 32'hAA);
        check("rr_mem1", {24'd0, mem[8'h50]}, 32'hBB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
